// File: rtl/miner_nonce_dispatcher.sv
// Nonce sweep initiator for the miner core: issues one hash per nonce, checks the
// returned digest against the latched target, and stops on hit, exhaustion, abort or watchdog.
module miner_nonce_dispatcher #(
  parameter int NONCE_W  = 32,
  parameter int HASH_W   = 256,
  parameter int WDOG_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_lo,
  input  logic [NONCE_W-1:0] nonce_hi,
  input  logic [HASH_W-1:0]  target,
  input  logic               finished,
  input  logic [HASH_W-1:0]  digest,
  output logic               hash_enable,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               exhausted,
  output logic               timeout
);

  localparam int WD_W = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [NONCE_W-1:0]   hi_q;
  logic [NONCE_W-1:0]   found_nonce_q;
  logic [HASH_W-1:0]    target_q;
  logic [WD_W-1:0]      wdog_q;
  logic                 hit_q;
  logic                 hash_enable_q;
  logic                 busy_q;
  logic                 found_q;
  logic                 exhausted_q;
  logic                 timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      nonce_q       <= '0;
      hi_q          <= '0;
      found_nonce_q <= '0;
      target_q      <= '0;
      wdog_q        <= '0;
      hit_q         <= 1'b0;
      hash_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      timeout_q   <= 1'b0;
      if (abort) begin
        state_q       <= S_IDLE;
        hash_enable_q <= 1'b0;
        busy_q        <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              hi_q     <= nonce_hi;
              target_q <= target;
              nonce_q  <= nonce_lo;
              if (nonce_lo > nonce_hi) begin
                exhausted_q <= 1'b1;
              end else begin
                state_q <= S_ISSUE;
                busy_q  <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            hash_enable_q <= 1'b1;
            wdog_q        <= '0;
            state_q       <= S_WAIT;
          end
          S_WAIT: begin
            // finished takes precedence over a watchdog expiring in the same cycle
            if (finished) begin
              hit_q         <= (digest < target_q);
              hash_enable_q <= 1'b0;
              state_q       <= S_CHECK;
            end else if (wdog_q == WD_LAST) begin
              hash_enable_q <= 1'b0;
              timeout_q     <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= S_IDLE;
            end else begin
              wdog_q <= wdog_q + 1'b1;
            end
          end
          S_CHECK: begin
            if (hit_q) begin
              found_nonce_q <= nonce_q;
              found_q       <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= S_DONE;
            end else if (nonce_q == hi_q) begin
              // equality stop keeps an all-ones upper bound from wrapping to zero
              exhausted_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_DONE;
            end else begin
              nonce_q <= nonce_q + 1'b1;
              state_q <= S_ISSUE;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign hash_enable = hash_enable_q;
  assign nonce       = nonce_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign exhausted   = exhausted_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
// Directed bench for miner_nonce_dispatcher: table of sweep jobs against a bench-side
// core responder, plus hand sequences for reset, abort and ignored start/finished.
module tb_miner_nonce_dispatcher;

  localparam int NW = 32;
  localparam int HW = 256;
  localparam logic [HW-1:0] TGT = {32'h0000_00FF, 224'h0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NW-1:0] nonce_lo = '0;
  logic [NW-1:0] nonce_hi = '0;
  logic [HW-1:0] target = TGT;
  logic          finished = 1'b0;
  logic [HW-1:0] digest = '0;
  logic          hash_enable, busy, found, exhausted, timeout;
  logic [NW-1:0] nonce, found_nonce;

  int nchecks = 0;
  int nerrors = 0;

  miner_nonce_dispatcher #(.NONCE_W(NW), .HASH_W(HW), .WDOG_CYC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .nonce_lo(nonce_lo), .nonce_hi(nonce_hi), .target(target),
    .finished(finished), .digest(digest),
    .hash_enable(hash_enable), .nonce(nonce), .busy(busy), .found(found),
    .found_nonce(found_nonce), .exhausted(exhausted), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [NW-1:0] lo;
    logic [NW-1:0] hi;
    bit            hit_en;
    logic [NW-1:0] hit_n;
    int            lat;     // cycles in WAIT before finished; 0 = core never answers
    int            e_iss;
    int            e_f;
    int            e_e;
    int            e_t;
    int            e_pcyc;  // negedge index (after start) where the end pulse is seen
    logic [NW-1:0] e_fn;
    bit            chk_n;
    logic [NW-1:0] e_n;
  } vec_t;

  vec_t vt[8];

  task automatic run_job(input int idx, input vec_t v);
    int cyc, issues, fcnt, ecnt, tcnt, pcyc, wcnt, post;
    logic prev_he, stable_ok;
    logic [NW-1:0] he_nonce;
    string p;
    cyc = 0; issues = 0; fcnt = 0; ecnt = 0; tcnt = 0; pcyc = 0; wcnt = 0; post = 0;
    prev_he = 1'b0; stable_ok = 1'b1; he_nonce = '0;
    @(negedge clk);
    nonce_lo = v.lo; nonce_hi = v.hi; target = TGT; start = 1'b1;
    while (post < 5 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      finished = 1'b0;
      if (hash_enable) begin
        if (!prev_he) begin
          issues++;
          he_nonce = nonce;
          wcnt = 0;
        end else if (nonce !== he_nonce) begin
          stable_ok = 1'b0;
        end
        wcnt++;
        if (v.lat != 0 && wcnt == v.lat) begin
          finished = 1'b1;
          digest = (v.hit_en && nonce == v.hit_n) ? TGT - 1'b1 : TGT;
        end
      end
      prev_he = hash_enable;
      if (found)     fcnt++;
      if (exhausted) ecnt++;
      if (timeout)   tcnt++;
      if (pcyc == 0 && (found || exhausted || timeout)) pcyc = cyc;
      if (pcyc != 0) post++;
    end
    p = $sformatf("job%0d", idx);
    chk({p, "_pulse_cyc"}, pcyc, v.e_pcyc);
    chk({p, "_issues"}, issues, v.e_iss);
    chk({p, "_found_cnt"}, fcnt, v.e_f);
    chk({p, "_exh_cnt"}, ecnt, v.e_e);
    chk({p, "_timeout_cnt"}, tcnt, v.e_t);
    chk({p, "_found_nonce"}, found_nonce, v.e_fn);
    chk({p, "_he_low"}, hash_enable, 0);
    chk({p, "_busy_low"}, busy, 0);
    chk({p, "_nonce_stable"}, stable_ok, 1);
    if (v.chk_n) chk({p, "_nonce_end"}, nonce, v.e_n);
  endtask

  task automatic wait_he(input string nm);
    int n;
    n = 0;
    while (!hash_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, hash_enable, 1);
  endtask

  int pulses, rises;
  logic prev;

  initial begin
    //          lo            hi            hit hit_n         lat iss f  e  t  pcyc fn            chk n
    vt[0] = '{32'd5,        32'd7,        0, 32'd0,        1,  3, 0, 1, 0, 10, 32'd0,        1, 32'd7};
    vt[1] = '{32'h10,       32'h20,       1, 32'h12,       2,  3, 1, 0, 0, 13, 32'h12,       1, 32'h12};
    vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd0,        3,  1, 0, 1, 0,  6, 32'h12,       1, 32'hFFFFFFFF};
    vt[3] = '{32'd9,        32'd3,        0, 32'd0,        1,  0, 0, 1, 0,  1, 32'h12,       0, 32'd0};
    vt[4] = '{32'd100,      32'd100,      1, 32'd100,      5,  1, 1, 0, 0,  8, 32'd100,      1, 32'd100};
    vt[5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1,  2, 1, 0, 0,  7, 32'hFFFFFFFF, 1, 32'hFFFFFFFF};
    vt[6] = '{32'd40,       32'd40,       0, 32'd0,        8,  1, 0, 1, 0, 11, 32'hFFFFFFFF, 1, 32'd40};
    vt[7] = '{32'd1,        32'd5,        0, 32'd0,        0,  1, 0, 0, 1, 10, 32'hFFFFFFFF, 1, 32'd1};

    #12;
    chk("rst_he", hash_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nonce", nonce, 0);
    chk("rst_pulses", {found, exhausted, timeout}, 0);
    chk("rst_found_nonce", found_nonce, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_job(i, vt[i]);

    // abort in WAIT, then a stray finished while IDLE
    nonce_lo = 32'd50; nonce_hi = 32'd60; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_he("abort_wait_he");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_he", hash_enable, 0);
    chk("abort_busy", busy, 0);
    pulses = 0; rises = 0;
    for (int k = 0; k < 6; k++) begin
      finished = (k == 1);
      digest = TGT - 1'b1;
      @(negedge clk);
      pulses += int'(found) + int'(exhausted) + int'(timeout);
      rises += int'(hash_enable);
    end
    finished = 1'b0;
    chk("abort_no_pulses", pulses, 0);
    chk("abort_no_issue", rises, 0);
    chk("abort_nonce_hold", nonce, 50);
    chk("abort_found_nonce", found_nonce, 32'hFFFFFFFF);

    // start while busy must not relatch range or target
    nonce_lo = 32'd70; nonce_hi = 32'd70; target = TGT; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_he("busy_wait_he");
    start = 1'b1; nonce_lo = 32'd200; nonce_hi = 32'd300; target = '0;
    @(negedge clk);
    start = 1'b0;
    finished = 1'b1; digest = TGT - 1'b1;
    @(negedge clk);
    finished = 1'b0;
    pulses = 0; rises = 0; prev = hash_enable;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pulses += int'(found);
      if (hash_enable && !prev) rises++;
      prev = hash_enable;
    end
    target = TGT;
    chk("busy_start_found", pulses, 1);
    chk("busy_start_found_nonce", found_nonce, 70);
    chk("busy_start_no_reissue", rises, 0);
    chk("busy_start_nonce", nonce, 70);

    // asynchronous reset in the middle of a job
    nonce_lo = 32'd3; nonce_hi = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_he("rst_wait_he");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_he", hash_enable, 0);
    chk("arst_busy", busy, 0);
    chk("arst_nonce", nonce, 0);
    chk("arst_found_nonce", found_nonce, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0; rises = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pulses += int'(found) + int'(exhausted) + int'(timeout);
      rises += int'(hash_enable) + int'(busy);
    end
    chk("arst_no_pulses", pulses, 0);
    chk("arst_idle", rises, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
